// File: rtl/ex_trap_sequencer_if.sv
// ex_trap_sequencer_if: memory-stage request bus between the trap sequencer
// (master) and the SP/memory mux of the MEM stage (slave).
interface ex_trap_sequencer_if;
    logic [1:0]  mem_op_out;
    logic [31:0] mem_addr_out;
    logic [15:0] mem_wdata_out;
    logic        mem_ready_in;
    logic [15:0] mem_rdata_in;

    modport master (
        output mem_op_out,
        output mem_addr_out,
        output mem_wdata_out,
        input  mem_ready_in,
        input  mem_rdata_in
    );

    modport slave (
        input  mem_op_out,
        input  mem_addr_out,
        input  mem_wdata_out,
        output mem_ready_in,
        output mem_rdata_in
    );
endinterface

// File: rtl/ex_trap_sequencer.sv
// ex_trap_sequencer: multi-cycle controller that freezes and drains the pipe on
// an interrupt, divide-by-zero exception or RTI, then walks the memory stage
// through the push/vector-read or pop micro-sequence and reloads PC and CCR.
// Optional build macro: ISR_MASK_EN adds an interrupt-enable bit that blocks
// nested interrupts until the handler returns.
module ex_trap_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] INT_VEC_ADDR = 32'd2,
    parameter logic [31:0] EXC_VEC_ADDR = 32'd4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        int_req_in,
    input  logic                        div0_exc_in,
    input  logic                        rti_in,
    input  logic [31:0]                 epc_in,
    input  logic [3:0]                  flags_in,
    ex_trap_sequencer_if.master         mem_bus,
    output logic                        stall_out,
    output logic                        flush_out,
    output logic                        pc_load_out,
    output logic [31:0]                 pc_value_out,
    output logic                        flags_load_out,
    output logic [3:0]                  flags_value_out,
    output logic                        busy_out,
    output logic                        trap_cause_out
);

    typedef enum logic [3:0] {
        IDLE, DRAIN, PUSH_PCH, PUSH_PCL, PUSH_FLG, RD_VL, RD_VH,
        REDIRECT, POP_FLG, POP_PCL, POP_PCH, RESTORE
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  drain_cnt_q;
    logic        int_pend_q;
    logic        cause_q;
    logic        rti_q;
    logic [31:0] epc_q;
    logic [3:0]  flags_q;
    logic [15:0] lo_q;
    logic [15:0] hi_q;
    logic [3:0]  pop_flags_q;
    logic        int_en;
    logic        int_pending;
    logic        take_exc, take_int, take_rti, accept;
    logic [31:0] vec_addr;
    logic [1:0]  mem_op;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;

`ifdef ISR_MASK_EN
    logic        int_en_q;
    assign int_en = int_en_q;
`else
    assign int_en = 1'b1;
`endif

    // Requests are only taken from IDLE and never while reset is asserted, so
    // the Mealy flush/stall outputs stay low during reset.
    assign int_pending = int_pend_q | int_req_in;
    assign take_exc    = reset && (state_q == IDLE) && div0_exc_in;
    assign take_int    = reset && (state_q == IDLE) && !div0_exc_in && int_pending && int_en;
    assign take_rti    = reset && (state_q == IDLE) && !div0_exc_in && !(int_pending && int_en) && rti_in;
    assign accept      = take_exc | take_int | take_rti;
    assign vec_addr    = cause_q ? EXC_VEC_ADDR : INT_VEC_ADDR;

    assign busy_out       = (state_q != IDLE);
    assign stall_out      = busy_out | accept;
    assign trap_cause_out = busy_out & cause_q;

    assign mem_bus.mem_op_out    = mem_op;
    assign mem_bus.mem_addr_out  = mem_addr;
    assign mem_bus.mem_wdata_out = mem_wdata;

    // State register; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and per-state bus / load outputs.
    always_comb begin
        state_d         = state_q;
        flush_out       = 1'b0;
        mem_op          = 2'b00;
        mem_addr        = 32'd0;
        mem_wdata       = 16'd0;
        pc_load_out     = 1'b0;
        pc_value_out    = 32'd0;
        flags_load_out  = 1'b0;
        flags_value_out = 4'b0000;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    flush_out = 1'b1;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) state_d = rti_q ? POP_FLG : PUSH_PCH;
            end
            PUSH_PCH: begin
                mem_op    = 2'b01;
                mem_wdata = epc_q[31:16];
                if (mem_bus.mem_ready_in) state_d = PUSH_PCL;
            end
            PUSH_PCL: begin
                mem_op    = 2'b01;
                mem_wdata = epc_q[15:0];
                if (mem_bus.mem_ready_in) state_d = PUSH_FLG;
            end
            PUSH_FLG: begin
                mem_op    = 2'b01;
                mem_wdata = {12'd0, flags_q};
                if (mem_bus.mem_ready_in) state_d = RD_VL;
            end
            RD_VL: begin
                mem_op   = 2'b11;
                mem_addr = vec_addr;
                if (mem_bus.mem_ready_in) state_d = RD_VH;
            end
            RD_VH: begin
                mem_op   = 2'b11;
                mem_addr = vec_addr + 32'd1;
                if (mem_bus.mem_ready_in) state_d = REDIRECT;
            end
            REDIRECT: begin
                pc_load_out    = 1'b1;
                pc_value_out   = {hi_q, lo_q};
                flags_load_out = 1'b1;
                state_d        = IDLE;
            end
            POP_FLG: begin
                mem_op = 2'b10;
                if (mem_bus.mem_ready_in) state_d = POP_PCL;
            end
            POP_PCL: begin
                mem_op = 2'b10;
                if (mem_bus.mem_ready_in) state_d = POP_PCH;
            end
            POP_PCH: begin
                mem_op = 2'b10;
                if (mem_bus.mem_ready_in) state_d = RESTORE;
            end
            RESTORE: begin
                pc_load_out     = 1'b1;
                pc_value_out    = {hi_q, lo_q};
                flags_load_out  = 1'b1;
                flags_value_out = pop_flags_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Trap context capture, drain counting, interrupt latch and read-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt_q <= 4'd0;
            int_pend_q  <= 1'b0;
            cause_q     <= 1'b0;
            rti_q       <= 1'b0;
            epc_q       <= 32'd0;
            flags_q     <= 4'd0;
            lo_q        <= 16'd0;
            hi_q        <= 16'd0;
            pop_flags_q <= 4'd0;
`ifdef ISR_MASK_EN
            int_en_q    <= 1'b1;
`endif
        end else begin
            int_pend_q <= int_pending & ~take_int;
            if (accept) begin
                cause_q     <= take_exc;
                rti_q       <= take_rti;
                drain_cnt_q <= 4'd0;
                if (!take_rti) begin
                    epc_q   <= epc_in;
                    flags_q <= flags_in;
                end
            end
            if (state_q == DRAIN) drain_cnt_q <= drain_cnt_q + 4'd1;
            if (mem_bus.mem_ready_in) begin
                case (state_q)
                    RD_VL, POP_PCL: lo_q        <= mem_bus.mem_rdata_in;
                    RD_VH, POP_PCH: hi_q        <= mem_bus.mem_rdata_in;
                    POP_FLG:        pop_flags_q <= mem_bus.mem_rdata_in[3:0];
                    default: ;
                endcase
            end
`ifdef ISR_MASK_EN
            if (state_q == REDIRECT && !cause_q) int_en_q <= 1'b0;
            if (state_q == RESTORE)              int_en_q <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_ex_trap_sequencer.sv
// tb_ex_trap_sequencer: directed scenarios for ex_trap_sequencer with a
// scoreboard of expected memory transactions and PC/CCR loads.
module tb_ex_trap_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        int_req_in, div0_exc_in, rti_in;
    logic [31:0] epc_in;
    logic [3:0]  flags_in;
    logic        stall_out, flush_out, pc_load_out, flags_load_out, busy_out, trap_cause_out;
    logic [31:0] pc_value_out;
    logic [3:0]  flags_value_out;

    ex_trap_sequencer_if mem_bus();

    ex_trap_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .int_req_in      (int_req_in),
        .div0_exc_in     (div0_exc_in),
        .rti_in          (rti_in),
        .epc_in          (epc_in),
        .flags_in        (flags_in),
        .mem_bus         (mem_bus.master),
        .stall_out       (stall_out),
        .flush_out       (flush_out),
        .pc_load_out     (pc_load_out),
        .pc_value_out    (pc_value_out),
        .flags_load_out  (flags_load_out),
        .flags_value_out (flags_value_out),
        .busy_out        (busy_out),
        .trap_cause_out  (trap_cause_out)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [15:0] data;
        logic        is_load;
        logic [31:0] pc;
        logic [3:0]  flg;
        logic        chk_cause;
        logic        cause;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] pop_q[$];
    int          load_steps[$];
    logic [15:0] vec_mem [0:7];
    int          vectors = 0;
    int          miscompares = 0;
    int          step_no = 0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic void exp_mem(input logic [1:0] op, input logic [31:0] addr, input logic [15:0] data,
                                    input logic chk, input logic cause);
        exp_t e;
        e = '{default: '0};
        e.op = op; e.addr = addr; e.data = data; e.chk_cause = chk; e.cause = cause;
        sb_q.push_back(e);
    endfunction

    function automatic void exp_load(input logic [31:0] pc, input logic [3:0] flg);
        exp_t e;
        e = '{default: '0};
        e.is_load = 1'b1; e.pc = pc; e.flg = flg;
        sb_q.push_back(e);
    endfunction

    function automatic void exp_trap(input logic [31:0] epc, input logic [3:0] flg, input logic cause,
                                     input logic [31:0] vec, input logic [31:0] handler);
        exp_mem(2'b01, 32'd0, epc[31:16], 1'b1, cause);
        exp_mem(2'b01, 32'd0, epc[15:0], 1'b1, cause);
        exp_mem(2'b01, 32'd0, {12'd0, flg}, 1'b1, cause);
        exp_mem(2'b11, vec, 16'd0, 1'b1, cause);
        exp_mem(2'b11, vec + 32'd1, 16'd0, 1'b1, cause);
        exp_load(handler, 4'b0000);
    endfunction

    function automatic int load_at(input int idx);
        return (load_steps.size() > idx) ? load_steps[idx] : -1;
    endfunction

    // Drive one cycle's inputs at the falling edge, then answer the memory request.
    task automatic applyStimulus(input logic irq, input logic div0, input logic rti, input logic ready);
        @(negedge clk);
        int_req_in = irq; div0_exc_in = div0; rti_in = rti;
        mem_bus.mem_ready_in = ready;
        step_no++;
        #1;
        case (mem_bus.mem_op_out)
            2'b11:   mem_bus.mem_rdata_in = vec_mem[mem_bus.mem_addr_out[2:0]];
            2'b10:   mem_bus.mem_rdata_in = (pop_q.size() > 0) ? pop_q[0] : 16'hDEAD;
            default: mem_bus.mem_rdata_in = 16'd0;
        endcase
        #1;
    endtask

    // Retire completed transactions and loads against the scoreboard.
    task automatic monitor();
        exp_t e;
        if (mem_bus.mem_op_out != 2'b00 && mem_bus.mem_ready_in) begin
            checkOutput("sb_has_mem_entry", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checkOutput("mem_op", mem_bus.mem_op_out, e.op);
                if (e.op == 2'b11) checkOutput("mem_addr", mem_bus.mem_addr_out, e.addr);
                if (e.op == 2'b01) checkOutput("mem_wdata", mem_bus.mem_wdata_out, e.data);
                if (e.chk_cause)   checkOutput("trap_cause", trap_cause_out, e.cause);
                if (mem_bus.mem_op_out == 2'b10 && pop_q.size() > 0) void'(pop_q.pop_front());
            end
        end
        if (pc_load_out) begin
            load_steps.push_back(step_no);
            checkOutput("sb_has_load_entry", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checkOutput("pc_flags_load", {flags_load_out, pc_value_out, flags_value_out},
                            {e.is_load, e.pc, e.flg});
            end
        end
    endtask

    task automatic step_cycle(input logic irq, input logic div0, input logic rti, input logic ready);
        applyStimulus(irq, div0, rti, ready);
        monitor();
    endtask

    task automatic run_until_drained(input string tag, input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || busy_out) && n < budget) begin
            step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        checkOutput(tag, {(sb_q.size() == 0), busy_out}, 2'b10);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        int_req_in = 1'b0; div0_exc_in = 1'b0; rti_in = 1'b0;
        mem_bus.mem_ready_in = 1'b1; mem_bus.mem_rdata_in = 16'd0;
        sb_q.delete(); pop_q.delete(); load_steps.delete();
        @(negedge clk);
        reset = 1'b1;
        step_no = 0;
    endtask

    function automatic logic [127:0] all_outputs();
        return {stall_out, flush_out, mem_bus.mem_op_out, mem_bus.mem_addr_out, mem_bus.mem_wdata_out,
                pc_load_out, pc_value_out, flags_load_out, flags_value_out, busy_out, trap_cause_out};
    endfunction

    // Hard stop in case a scenario wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios.
    initial begin
        vec_mem[0] = 16'h0; vec_mem[1] = 16'h0;
        vec_mem[2] = 16'h0040; vec_mem[3] = 16'h0000;
        vec_mem[4] = 16'h0100; vec_mem[5] = 16'h0000;
        vec_mem[6] = 16'h0; vec_mem[7] = 16'h0;
        reset = 1'b0;
        int_req_in = 1'b0; div0_exc_in = 1'b0; rti_in = 1'b0;
        epc_in = 32'd0; flags_in = 4'd0;
        mem_bus.mem_ready_in = 1'b1; mem_bus.mem_rdata_in = 16'd0;

        // Reset state, with a request present that must not leak out.
        @(negedge clk);
        int_req_in = 1'b1;
        #1;
        checkOutput("reset_outputs", all_outputs(), 128'd0);
        int_req_in = 1'b0;

        // Interrupt entry, PC load on cycle 10.
        $display("[TB] interrupt entry");
        do_reset();
        epc_in = 32'h0001_2345; flags_in = 4'b1010;
        exp_trap(32'h0001_2345, 4'b1010, 1'b0, 32'd2, 32'h0000_0040);
        step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("int_accept_flush_stall_busy", {flush_out, stall_out, busy_out}, 3'b110);
        step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("int_flush_one_cycle", {flush_out, stall_out, busy_out}, 3'b011);
        run_until_drained("int_drained", 40);
        checkOutput("int_load_cycle", load_at(0), 10);

        // Exception and interrupt together: exception first, interrupt after.
        $display("[TB] exception with simultaneous interrupt");
        do_reset();
        epc_in = 32'h0000_1000; flags_in = 4'b0011;
        exp_trap(32'h0000_1000, 4'b0011, 1'b1, 32'd4, 32'h0000_0100);
        exp_trap(32'h0000_1000, 4'b0011, 1'b0, 32'd2, 32'h0000_0040);
        step_cycle(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("exc_accept_flush", flush_out, 1'b1);
        run_until_drained("exc_int_drained", 60);
        checkOutput("exc_int_load_cycles", {load_at(0), load_at(1)}, {32'd10, 32'd20});

        // RTI restores popped PC and flags.
        $display("[TB] return from interrupt");
        do_reset();
        pop_q.push_back(16'h0005); pop_q.push_back(16'h2345); pop_q.push_back(16'h0001);
        exp_mem(2'b10, 32'd0, 16'd0, 1'b0, 1'b0);
        exp_mem(2'b10, 32'd0, 16'd0, 1'b0, 1'b0);
        exp_mem(2'b10, 32'd0, 16'd0, 1'b0, 1'b0);
        exp_load(32'h0001_2345, 4'b0101);
        step_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rti_accept_flush", {flush_out, stall_out}, 2'b11);
        run_until_drained("rti_drained", 40);
        checkOutput("rti_load_cycle", load_at(0), 8);

        // Memory wait states in PUSH_PCL.
        $display("[TB] wait states");
        do_reset();
        epc_in = 32'h0001_2345; flags_in = 4'b1010;
        exp_trap(32'h0001_2345, 4'b1010, 1'b0, 32'd2, 32'h0000_0040);
        step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("hold_push_pcl", {busy_out, stall_out, mem_bus.mem_op_out, mem_bus.mem_wdata_out},
                        {1'b1, 1'b1, 2'b01, 16'h2345});
        end
        run_until_drained("wait_drained", 40);
        checkOutput("wait_load_cycle", load_at(0), 14);

        // Reset asserted during RD_VH.
        $display("[TB] reset mid-sequence");
        do_reset();
        epc_in = 32'h0001_2345; flags_in = 4'b1010;
        exp_mem(2'b01, 32'd0, 16'h0001, 1'b1, 1'b0);
        exp_mem(2'b01, 32'd0, 16'h2345, 1'b1, 1'b0);
        exp_mem(2'b01, 32'd0, 16'h000A, 1'b1, 1'b0);
        exp_mem(2'b11, 32'd2, 16'd0, 1'b1, 1'b0);
        step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (7) step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("in_rd_vh", {mem_bus.mem_op_out, mem_bus.mem_addr_out}, {2'b11, 32'd3});
        reset = 1'b0;
        #1;
        checkOutput("reset_mid_outputs", all_outputs(), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("no_load_after_reset", {pc_load_out, busy_out}, 2'b00);
        end
        checkOutput("reset_sb_consumed", sb_q.size(), 0);

        // Second interrupt raised while the first is being entered.
        $display("[TB] interrupt during handler");
        do_reset();
        epc_in = 32'h0001_2345; flags_in = 4'b1010;
        exp_trap(32'h0001_2345, 4'b1010, 1'b0, 32'd2, 32'h0000_0040);
`ifndef ISR_MASK_EN
        exp_trap(32'h0001_2345, 4'b1010, 1'b0, 32'd2, 32'h0000_0040);
`endif
        step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        run_until_drained("nest_drained", 80);
`ifndef ISR_MASK_EN
        checkOutput("nested_load_cycles", {load_at(0), load_at(1)}, {32'd10, 32'd20});
`else
        checkOutput("masked_single_load", load_steps.size(), 1);
        for (int i = 0; i < 3; i++) begin
            step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("masked_pending_idle", busy_out, 1'b0);
        end
        pop_q.push_back(16'h000A); pop_q.push_back(16'h2345); pop_q.push_back(16'h0001);
        exp_mem(2'b10, 32'd0, 16'd0, 1'b0, 1'b0);
        exp_mem(2'b10, 32'd0, 16'd0, 1'b0, 1'b0);
        exp_mem(2'b10, 32'd0, 16'd0, 1'b0, 1'b0);
        exp_load(32'h0001_2345, 4'b1010);
        exp_trap(32'h0001_2345, 4'b1010, 1'b0, 32'd2, 32'h0000_0040);
        step_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        run_until_drained("masked_rti_drained", 80);
        checkOutput("masked_total_loads", load_steps.size(), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
